// File: rtl/tag_rr_arb4.sv
// tag_rr_arb4 -- round-robin merge of SNUM Decoupled tag streams into one
// registered output channel. A granted input may keep the output for up to
// HOLD back-to-back transfers. After that, priority rotates past it.
//
// Ports:
//   iClk  : clock, rising edge
//   iRst  : synchronous active-high reset
//   iVld  : per-input valid                [SNUM]
//   iPld  : per-input payload, input k at  [k*DW +: DW]
//   iDst  : per-input destination, k at    [k*AW +: AW]
//   oRdy  : per-input ready, at most one bit set
//   oVld  : registered output valid
//   oPld  : registered output payload
//   oDst  : registered output destination
//   iRdy  : downstream ready
//   oGnt  : registered one-hot index of the last accepted input (diagnostic)
module tag_rr_arb4 #(
    parameter int unsigned DW   = 21,
    parameter int unsigned AW   = 4,
    parameter int unsigned SNUM = 4,
    parameter int unsigned HOLD = 4
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic [SNUM-1:0]    iVld,
    input  logic [SNUM*DW-1:0] iPld,
    input  logic [SNUM*AW-1:0] iDst,
    output logic [SNUM-1:0]    oRdy,
    output logic               oVld,
    output logic [DW-1:0]      oPld,
    output logic [AW-1:0]      oDst,
    input  logic               iRdy,
    output logic [SNUM-1:0]    oGnt
);

    localparam int unsigned PW = (SNUM > 1) ? $clog2(SNUM) : 1;

    logic [PW-1:0]   ptrQ;
    logic [PW-1:0]   ownerQ;
    logic [3:0]      cntQ;
    logic            lockQ;
    logic            vldQ;
    logic [DW-1:0]   pldQ;
    logic [AW-1:0]   dstQ;
    logic [SNUM-1:0] gntQ;

    logic            ld;
    logic            hold;
    logic            rrHit;
    logic [PW-1:0]   rrSel;
    logic [PW-1:0]   sel;
    logic            anyReq;
    logic            xfer;
    logic [PW-1:0]   selNext;
    logic [DW-1:0]   selPld;
    logic [AW-1:0]   selDst;

    // The slice can take new data when it is empty or being drained this cycle.
    assign ld   = !vldQ || iRdy;
    assign hold = lockQ && iVld[ownerQ] && (cntQ < 4'(HOLD));

    // Round-robin search starting at ptrQ, wrapping modulo SNUM.
    always_comb begin
        rrHit = 1'b0;
        rrSel = '0;
        for (int unsigned i = 0; i < SNUM; i++) begin
            int unsigned idx;
            idx = (int'(ptrQ) + i) % SNUM;
            if (!rrHit && iVld[idx]) begin
                rrHit = 1'b1;
                rrSel = PW'(idx);
            end
        end
    end

    assign sel     = hold ? ownerQ : rrSel;
    assign anyReq  = hold || (|iVld);
    assign selNext = (int'(sel) == SNUM - 1) ? '0 : sel + PW'(1);
    assign selPld  = iPld[int'(sel)*DW +: DW];
    assign selDst  = iDst[int'(sel)*AW +: AW];

    always_comb begin
        oRdy = '0;
        if (ld && anyReq && !iRst) begin
            oRdy[sel] = 1'b1;
        end
    end

    assign xfer = |(oRdy & iVld);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            vldQ   <= 1'b0;
            pldQ   <= '0;
            dstQ   <= '0;
            gntQ   <= '0;
            ptrQ   <= '0;
            ownerQ <= '0;
            cntQ   <= '0;
            lockQ  <= 1'b0;
        end else if (ld) begin
            if (xfer) begin
                vldQ      <= 1'b1;
                pldQ      <= selPld;
                dstQ      <= selDst;
                gntQ      <= '0;
                gntQ[sel] <= 1'b1;
                lockQ     <= 1'b1;
                if (lockQ && (sel == ownerQ)) begin
                    // Saturate so a lone requester running past HOLD never
                    // wraps back into hold eligibility.
                    cntQ <= (cntQ == 4'hF) ? cntQ : cntQ + 4'd1;
                end else begin
                    ownerQ <= sel;
                    cntQ   <= 4'd1;
                    ptrQ   <= selNext;
                end
            end else begin
                // An idle load cycle empties the slice and forfeits the burst.
                vldQ  <= 1'b0;
                lockQ <= 1'b0;
            end
        end
    end

    assign oVld = vldQ;
    assign oPld = pldQ;
    assign oDst = dstQ;
    assign oGnt = gntQ;

endmodule

// File: tb/tb_tag_rr_arb4.sv
// Directed bench for tag_rr_arb4. dutA uses HOLD=4 and dutB uses HOLD=1.
// The driver pushes the expected output beat for each hand-computed grant
// into a queue. A monitor compares every presented beat against the head of
// that queue.
module tb_tag_rr_arb4;

    localparam int DW = 21;
    localparam int AW = 4;
    localparam int SN = 4;

    typedef struct {
        logic [DW-1:0] pld;
        logic [AW-1:0] dst;
        logic [SN-1:0] gnt;
    } expT;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [SN-1:0]    vld = '1;
    logic [SN*DW-1:0] pld = '0;
    logic [SN*AW-1:0] dst = '0;
    logic             rdy = 1'b1;
    logic             useB = 1'b0;

    logic [SN-1:0] rdyA, rdyB, gntA, gntB;
    logic          oVldA, oVldB;
    logic [DW-1:0] pldA, pldB;
    logic [AW-1:0] dstA, dstB;

    logic [SN-1:0] mRdy, mGnt;
    logic          mVld;
    logic [DW-1:0] mPld;
    logic [AW-1:0] mDst;

    int  checks = 0;
    int  failures = 0;
    int  seq [SN];
    expT sbQ [$];

    always #5 clk = ~clk;

    tag_rr_arb4 #(.DW(DW), .AW(AW), .SNUM(SN), .HOLD(4)) dutA (
        .iClk(clk), .iRst(rst), .iVld(vld), .iPld(pld), .iDst(dst),
        .oRdy(rdyA), .oVld(oVldA), .oPld(pldA), .oDst(dstA), .iRdy(rdy), .oGnt(gntA)
    );

    tag_rr_arb4 #(.DW(DW), .AW(AW), .SNUM(SN), .HOLD(1)) dutB (
        .iClk(clk), .iRst(rst), .iVld(vld), .iPld(pld), .iDst(dst),
        .oRdy(rdyB), .oVld(oVldB), .oPld(pldB), .oDst(dstB), .iRdy(rdy), .oGnt(gntB)
    );

    assign mRdy = useB ? rdyB  : rdyA;
    assign mVld = useB ? oVldB : oVldA;
    assign mPld = useB ? pldB  : pldA;
    assign mDst = useB ? dstB  : dstA;
    assign mGnt = useB ? gntB  : gntA;

    function automatic logic [DW-1:0] mkPld(input int k, input int s);
        return DW'((k << 16) | (s & 16'hFFFF));
    endfunction

    function automatic logic [AW-1:0] mkDst(input int k, input int s);
        return AW'((k * 5 + s) & 15);
    endfunction

    task automatic drivePayloads();
        for (int k = 0; k < SN; k++) begin
            pld[k*DW +: DW] = mkPld(k, seq[k]);
            dst[k*AW +: AW] = mkDst(k, seq[k]);
        end
    endtask

    // One clock of stimulus. g is the hand-computed granted input, -1 for none.
    task automatic cyc(input logic [SN-1:0] v, input logic r, input int g);
        logic [SN-1:0] expRdy;
        expT e;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vld = v;
        rdy = r;
        drivePayloads();
        @(negedge clk);
        expRdy = (g >= 0) ? (SN'(1) << g) : '0;
        checks++;
        if (mRdy !== expRdy) begin
            failures++;
            $display("FAIL oRdy t=%0t got=%b want=%b", $time, mRdy, expRdy);
        end
        if (g >= 0) begin
            e.pld = mkPld(g, seq[g]);
            e.dst = mkDst(g, seq[g]);
            e.gnt = SN'(1) << g;
            sbQ.push_back(e);
            seq[g]++;
        end
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            vld = '1;
            rdy = 1'b1;
            @(negedge clk);
            checks++;
            if (mRdy !== '0) begin
                failures++;
                $display("FAIL reset_ordy t=%0t got=%b want=0", $time, mRdy);
            end
            if (i > 0) begin
                checks++;
                if (mVld !== 1'b0 || mGnt !== '0) begin
                    failures++;
                    $display("FAIL reset_state t=%0t oVld=%b oGnt=%b want 0/0", $time, mVld,
                             mGnt);
                end
            end
        end
    endtask

    task automatic drainAndCheck();
        cyc('0, 1'b1, -1);
        cyc('0, 1'b1, -1);
        checks++;
        if (sbQ.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty t=%0t pending=%0d want=0", $time, sbQ.size());
        end
    endtask

    // Monitor: every presented beat must match the queue head. The head is
    // retired only when downstream accepts, so stalled beats are rechecked.
    always @(negedge clk) begin
        if (mVld === 1'b1) begin
            checks++;
            if (sbQ.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat t=%0t pld=%h gnt=%b", $time, mPld, mGnt);
            end else begin
                if (mPld !== sbQ[0].pld || mDst !== sbQ[0].dst || mGnt !== sbQ[0].gnt) begin
                    failures++;
                    $display("FAIL beat t=%0t got pld=%h dst=%h gnt=%b want pld=%h dst=%h gnt=%b",
                             $time, mPld, mDst, mGnt, sbQ[0].pld, sbQ[0].dst, sbQ[0].gnt);
                end
                if (rdy) begin
                    void'(sbQ.pop_front());
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < SN; k++) seq[k] = 0;
        drivePayloads();

        // Reset / idle, then first grant goes to input 0.
        doReset(3);
        cyc(4'hF, 1'b1, 0);
        drainAndCheck();

        // Burst hold: inputs 0 and 2.
        doReset(2);
        for (int i = 0; i < 4; i++) cyc(4'b0101, 1'b1, 0);
        for (int i = 0; i < 4; i++) cyc(4'b0101, 1'b1, 2);
        cyc(4'b0101, 1'b1, 0);
        drainAndCheck();

        // Burst forfeit: input 1 drops for a cycle, input 3 always valid.
        doReset(2);
        cyc(4'b1010, 1'b1, 1);
        cyc(4'b1010, 1'b1, 1);
        cyc(4'b1000, 1'b1, 3);
        for (int i = 0; i < 3; i++) cyc(4'b1010, 1'b1, 3);
        for (int i = 0; i < 4; i++) cyc(4'b1010, 1'b1, 1);
        cyc(4'b1010, 1'b1, 3);
        drainAndCheck();

        // Backpressure on a stream from input 2.
        doReset(2);
        cyc(4'b0100, 1'b1, 2);
        cyc(4'b0100, 1'b1, 2);
        for (int i = 0; i < 5; i++) cyc(4'b0100, 1'b0, -1);
        for (int i = 0; i < 3; i++) cyc(4'b0100, 1'b1, 2);
        drainAndCheck();

        // Mid-burst reset with input 0 at cnt=2, then cnt restarts at 1.
        doReset(2);
        cyc(4'b0001, 1'b1, 0);
        cyc(4'b0001, 1'b1, 0);
        doReset(2);
        for (int i = 0; i < 4; i++) cyc(4'b0011, 1'b1, 0);
        cyc(4'b0011, 1'b1, 1);
        drainAndCheck();

        // Wrap-around with HOLD=1.
        useB = 1'b1;
        doReset(2);
        cyc(4'hF, 1'b1, 0);
        cyc(4'hF, 1'b1, 1);
        cyc(4'hF, 1'b1, 2);
        cyc(4'hF, 1'b1, 3);
        cyc(4'hF, 1'b1, 0);
        cyc(4'hF, 1'b1, 1);
        for (int i = 0; i < 3; i++) cyc(4'b1000, 1'b1, 3);
        cyc(4'b1001, 1'b1, 0);
        cyc(4'b1001, 1'b1, 3);
        cyc(4'b1001, 1'b1, 0);
        drainAndCheck();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
